// File: rtl/proc_pkg.sv
// Shared processor definitions.
//   PC_W        : instruction address width, common to the program counter,
//                 InstROM and the branch LUT.
//   pc_state_t  : fetch sequencer state (IDLE before the first Start,
//                 RUN while fetching, DONE after a halt).
package proc_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage : proc_pkg

// File: rtl/prog_ctr.sv
// Program counter / fetch sequencer feeding InstROM.
// ProgCtr advances by one per RUN cycle. It jumps to Target on a taken je/jne
// and freezes on halt. Start (accepted in IDLE or DONE) restarts the program
// at START_ADDR. InstCount counts retired instructions since the last Start
// and saturates at its maximum value.
//
// Ports
//   Clk        in   clock, all state on the rising edge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   begin/restart program (ignored while running)
//   Halt       in   current instruction is halt
//   BranchEn   in   current instruction is je/jne
//   BranchNe   in   0 = je (taken on Zero=1), 1 = jne (taken on Zero=0)
//   Zero       in   ALU zero flag from the previous compare
//   Target     in   absolute branch target
//   ProgCtr    out  fetch address to InstROM
//   Running    out  high while in RUN
//   Done       out  high while in DONE
//   InstCount  out  instructions retired since last Start
module prog_ctr
  import proc_pkg::*;
#(
  parameter int             A          = PC_W,
  parameter logic [A-1:0]   START_ADDR = '0,
  parameter int             CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchNe,
  input  logic          Zero,
  input  logic [A-1:0]  Target,
  output logic [A-1:0]  ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] InstCount
);

  pc_state_t     state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          running_q, done_q;
  logic          taken;

  // Next-state, next-PC and taken decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    // je is taken on Zero=1, jne on Zero=0.
    taken   = BranchEn & (Zero ^ BranchNe);

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_d    = START_ADDR;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The halt cycle retires an instruction too.
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (Halt) begin
          // Halt outranks a simultaneous taken branch; the halt address stays
          // on ProgCtr.
          state_d = DONE;
        end else if (taken) begin
          pc_d = Target;
        end else begin
          pc_d = pc_q + A'(1);  // wraps modulo 2**A
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      // Status flags are registered decodes of the next state, so they
      // always line up with state_q and are never both high.
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign ProgCtr   = pc_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign InstCount = cnt_q;

endmodule : prog_ctr

// File: tb/tb_prog_ctr.sv
module tb_prog_ctr;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0, Halt = 1'b0, BranchEn = 1'b0, BranchNe = 1'b0, Zero = 1'b0;
  logic [9:0]  Target = '0;
  logic [9:0]  ProgCtr, pc4;
  logic        Running, Done, run4, done4;
  logic [15:0] InstCount;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: program position, run/done status, retired counts.
  int m_pc, m_cnt, m_cnt4;
  bit m_run, m_done;

  prog_ctr dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
    .BranchEn(BranchEn), .BranchNe(BranchNe), .Zero(Zero), .Target(Target),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstCount(InstCount)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  prog_ctr #(.CW(4)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
    .BranchEn(BranchEn), .BranchNe(BranchNe), .Zero(Zero), .Target(Target),
    .ProgCtr(pc4), .Running(run4), .Done(done4), .InstCount(cnt4)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_run = 0; m_done = 0;
  endtask

  // One clock of the specified behaviour.
  task automatic model_step(input bit st, h, be, bn, z, input int tg);
    if (m_run) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
      if (h) begin
        m_run = 0; m_done = 1;
      end else if (be && ((!bn && z) || (bn && !z))) begin
        m_pc = tg;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end else if (st) begin
      m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_run = 1; m_done = 0;
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic cyc(input bit st, h, be, bn, z, input int tg);
    Start = st; Halt = h; BranchEn = be; BranchNe = bn; Zero = z;
    Target = 10'(tg);
    @(posedge Clk);
    model_step(st, h, be, bn, z, tg);
    #1;
  endtask

  // Taken je to an address (used to position the PC).
  task automatic go_to(input int a);
    cyc(0, 0, 1, 0, 1, a);
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (ProgCtr !== 10'd0 || InstCount !== 16'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: pc=%0d cnt=%0d run=%b done=%b, required 0 0 0 0",
               ProgCtr, InstCount, Running, Done);
    end
    @(negedge Clk) Reset_n = 1'b1;
    // Idle without Start holds everything, even with Halt/BranchEn active.
    cyc(0, 1, 1, 0, 1, 77);
    cyc(0, 0, 1, 1, 0, 99);
    n_checks++;
    if (ProgCtr !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 || InstCount !== 16'd0) begin
      n_errors++;
      $display("FAIL idle_hold: pc=%0d run=%b done=%b cnt=%0d, required 0 0 0 0",
               ProgCtr, Running, Done, InstCount);
    end
  endtask

  task automatic test_sequential();
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ProgCtr !== 10'(m_pc) || InstCount !== 16'(m_cnt) || Running !== 1'b1 || Done !== 1'b0) begin
        n_errors++;
        $display("FAIL seq[%0d]: pc=%0d cnt=%0d run=%b done=%b, required pc=%0d cnt=%0d run=1 done=0",
                 i, ProgCtr, InstCount, Running, Done, m_pc, m_cnt);
      end
      cyc(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_branch();
    // je taken (Zero=1) then not taken (Zero=0) from 5.
    go_to(5);
    cyc(0, 0, 1, 0, 1, 40);
    n_checks++;
    if (ProgCtr !== 10'd40) begin
      n_errors++; $display("FAIL je_taken: pc=%0d, required 40", ProgCtr);
    end
    go_to(5);
    cyc(0, 0, 1, 0, 0, 40);
    n_checks++;
    if (ProgCtr !== 10'd6) begin
      n_errors++; $display("FAIL je_not_taken: pc=%0d, required 6", ProgCtr);
    end
    // jne taken (Zero=0) then not taken (Zero=1) from 9.
    go_to(9);
    cyc(0, 0, 1, 1, 0, 3);
    n_checks++;
    if (ProgCtr !== 10'd3) begin
      n_errors++; $display("FAIL jne_taken: pc=%0d, required 3", ProgCtr);
    end
    go_to(9);
    cyc(0, 0, 1, 1, 1, 3);
    n_checks++;
    if (ProgCtr !== 10'd10) begin
      n_errors++; $display("FAIL jne_not_taken: pc=%0d, required 10", ProgCtr);
    end
    // Branch to own address loops in place.
    go_to(200);
    cyc(0, 0, 1, 0, 1, 200);
    cyc(0, 0, 1, 0, 1, 200);
    n_checks++;
    if (ProgCtr !== 10'd200) begin
      n_errors++; $display("FAIL self_loop: pc=%0d, required 200", ProgCtr);
    end
  endtask

  task automatic test_wrap();
    go_to(1023);
    n_checks++;
    if (ProgCtr !== 10'd1023) begin
      n_errors++; $display("FAIL wrap_setup: pc=%0d, required 1023", ProgCtr);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (ProgCtr !== 10'd0) begin
      n_errors++; $display("FAIL wrap: pc=%0d, required 0", ProgCtr);
    end
  endtask

  task automatic test_halt();
    go_to(12);
    cyc(0, 1, 1, 0, 1, 55);  // halt with a taken je
    n_checks++;
    if (ProgCtr !== 10'd12 || Done !== 1'b1 || Running !== 1'b0 || InstCount !== 16'(m_cnt)) begin
      n_errors++;
      $display("FAIL halt_priority: pc=%0d done=%b run=%b cnt=%0d, required 12 1 0 %0d",
               ProgCtr, Done, Running, InstCount, m_cnt);
    end
    // DONE ignores Halt/branches and holds.
    cyc(0, 0, 1, 0, 1, 300);
    cyc(0, 1, 0, 0, 0, 0);
    n_checks++;
    if (ProgCtr !== 10'd12 || Done !== 1'b1 || InstCount !== 16'(m_cnt)) begin
      n_errors++;
      $display("FAIL done_hold: pc=%0d done=%b cnt=%0d, required 12 1 %0d",
               ProgCtr, Done, InstCount, m_cnt);
    end
    cyc(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (ProgCtr !== 10'd0 || InstCount !== 16'd0 || Running !== 1'b1 || Done !== 1'b0) begin
      n_errors++;
      $display("FAIL restart: pc=%0d cnt=%0d run=%b done=%b, required 0 0 1 0",
               ProgCtr, InstCount, Running, Done);
    end
  endtask

  task automatic test_reset_mid_run();
    go_to(7);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (ProgCtr !== 10'd0 || InstCount !== 16'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_run: pc=%0d cnt=%0d run=%b done=%b, required 0 0 0 0",
               ProgCtr, InstCount, Running, Done);
    end
    @(negedge Clk) Reset_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);  // Start in RUN is ignored
    n_checks++;
    if (ProgCtr !== 10'd3 || InstCount !== 16'd3 || Running !== 1'b1) begin
      n_errors++;
      $display("FAIL start_in_run: pc=%0d cnt=%0d run=%b, required 3 3 1",
               ProgCtr, InstCount, Running);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (cnt4 !== 4'(m_cnt4) || cnt4 !== 4'd15 || InstCount !== 16'(m_cnt)) begin
      n_errors++;
      $display("FAIL saturation: cnt4=%0d cnt=%0d, required 15 %0d", cnt4, InstCount, m_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit st, h, be, bn, z;
      int tg;
      st = ($urandom_range(0, 9) == 0);
      h  = ($urandom_range(0, 24) == 0);
      be = ($urandom_range(0, 3) == 0);
      bn = 1'($urandom);
      z  = 1'($urandom);
      tg = $urandom_range(0, 1023);
      cyc(st, h, be, bn, z, tg);
      n_checks++;
      if (ProgCtr !== 10'(m_pc) || Running !== m_run || Done !== m_done ||
          InstCount !== 16'(m_cnt) || cnt4 !== 4'(m_cnt4) || pc4 !== 10'(m_pc)) begin
        n_errors++;
        $display("FAIL random[%0d]: pc=%0d run=%b done=%b cnt=%0d cnt4=%0d, required pc=%0d run=%b done=%b cnt=%0d cnt4=%0d",
                 i, ProgCtr, Running, Done, InstCount, cnt4, m_pc, m_run, m_done, m_cnt, m_cnt4);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_prog_ctr
